// File: rtl/reg_write_arbiter.sv
// Shares one register-file write port among N_REQ execute units via per-requester FIFOs.
// Define REG_WRITE_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module reg_write_arbiter #(
  parameter int N_REQ         = 2,
  parameter int DEPTH         = 2,
  parameter int LEN_PREG_ADDR = 6,
  parameter int LEN_WORD      = 32,
  parameter int LEN_CONTEXT   = 4
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [N_REQ-1:0]                 in_valid,
  input  logic [N_REQ*LEN_PREG_ADDR-1:0]   in_pa_rd,
  input  logic [N_REQ*LEN_WORD-1:0]        in_data,
  input  logic [N_REQ*LEN_CONTEXT-1:0]     in_context,
  output logic [N_REQ-1:0]                 in_ready,
  input  logic                             branch_hazard,
  input  logic [LEN_CONTEXT-1:0]           hazard_context_info,
  output logic                             w_order,
  output logic [LEN_PREG_ADDR-1:0]         w_pa_rd,
  output logic [LEN_WORD-1:0]              w_d_rd,
  output logic [$clog2(N_REQ)-1:0]         w_grant_id,
  output logic                             pending
);

  localparam int GW = $clog2(N_REQ);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic                     r_live [N_REQ][DEPTH];
  logic [LEN_PREG_ADDR-1:0] r_pa   [N_REQ][DEPTH];
  logic [LEN_WORD-1:0]      r_data [N_REQ][DEPTH];
  logic [LEN_CONTEXT-1:0]   r_ctx  [N_REQ][DEPTH];
  logic [PW-1:0]            r_rd_ptr [N_REQ];
  logic [PW-1:0]            r_wr_ptr [N_REQ];
  logic [CW-1:0]            r_cnt    [N_REQ];

  logic                     r_out_valid;
  logic [LEN_PREG_ADDR-1:0] r_out_pa;
  logic [LEN_WORD-1:0]      r_out_data;
  logic [LEN_CONTEXT-1:0]   r_out_ctx;
  logic [GW-1:0]            r_out_gnt;
`ifndef REG_WRITE_ARB_FIXED_PRIO_EN
  logic [GW-1:0]            r_rr_ptr;
  int                       w_idx;
`endif

  logic [LEN_CONTEXT-1:0]   w_hz_info;
  logic [N_REQ-1:0]         w_ready;
  logic [N_REQ-1:0]         w_hd_live;
  logic [N_REQ-1:0]         w_elig;
  logic [N_REQ-1:0]         w_push;
  logic [N_REQ-1:0]         w_pop;
  logic                     w_found;
  logic [GW-1:0]            w_win;

  function automatic logic f_match(input logic [LEN_CONTEXT-1:0] c,
                                   input logic [LEN_CONTEXT-1:0] m);
    return |(c & m);
  endfunction

  assign w_hz_info = branch_hazard ? hazard_context_info : '0;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_ready[i]   = r_cnt[i] < CW'(DEPTH);
      w_hd_live[i] = (r_cnt[i] != '0) && r_live[i][r_rd_ptr[i]];
      w_elig[i]    = w_hd_live[i] && !f_match(r_ctx[i][r_rd_ptr[i]], w_hz_info);
      // r0 writes and already-flushed producers never enter the FIFO
      w_push[i]    = in_valid[i] && w_ready[i]
                     && (in_pa_rd[i*LEN_PREG_ADDR +: LEN_PREG_ADDR] != '0)
                     && !f_match(in_context[i*LEN_CONTEXT +: LEN_CONTEXT], w_hz_info);
    end
`ifdef REG_WRITE_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_elig[k]) begin
        w_found = 1'b1;
        w_win   = GW'(k);
      end
    end
`else
    w_idx = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = GW'(w_idx);
      end
    end
`endif
    for (int i = 0; i < N_REQ; i++) begin
      w_pop[i] = (r_cnt[i] != '0) && (!w_hd_live[i] || (w_found && (w_win == GW'(i))));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_REQ; i++) begin
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
        r_cnt[i]    <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          r_live[i][d] <= 1'b0;
          r_pa[i][d]   <= '0;
          r_data[i][d] <= '0;
          r_ctx[i][d]  <= '0;
        end
      end
      r_out_valid <= 1'b0;
      r_out_pa    <= '0;
      r_out_data  <= '0;
      r_out_ctx   <= '0;
      r_out_gnt   <= '0;
`ifndef REG_WRITE_ARB_FIXED_PRIO_EN
      r_rr_ptr    <= GW'(N_REQ - 1);
`endif
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        for (int d = 0; d < DEPTH; d++) begin
          if (f_match(r_ctx[i][d], w_hz_info)) r_live[i][d] <= 1'b0;
        end
        if (w_pop[i]) begin
          r_live[i][r_rd_ptr[i]] <= 1'b0;
          r_rd_ptr[i]            <= r_rd_ptr[i] + PW'(1);
        end
        if (w_push[i]) begin
          r_live[i][r_wr_ptr[i]] <= 1'b1;
          r_pa[i][r_wr_ptr[i]]   <= in_pa_rd[i*LEN_PREG_ADDR +: LEN_PREG_ADDR];
          r_data[i][r_wr_ptr[i]] <= in_data[i*LEN_WORD +: LEN_WORD];
          r_ctx[i][r_wr_ptr[i]]  <= in_context[i*LEN_CONTEXT +: LEN_CONTEXT];
          r_wr_ptr[i]            <= r_wr_ptr[i] + PW'(1);
        end
        if (w_push[i] && !w_pop[i])      r_cnt[i] <= r_cnt[i] + CW'(1);
        else if (!w_push[i] && w_pop[i]) r_cnt[i] <= r_cnt[i] - CW'(1);
      end
      if (w_found) begin
        r_out_valid <= 1'b1;
        r_out_pa    <= r_pa[w_win][r_rd_ptr[w_win]];
        r_out_data  <= r_data[w_win][r_rd_ptr[w_win]];
        r_out_ctx   <= r_ctx[w_win][r_rd_ptr[w_win]];
        r_out_gnt   <= w_win;
`ifndef REG_WRITE_ARB_FIXED_PRIO_EN
        r_rr_ptr    <= w_win;
`endif
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    pending = r_out_valid;
    for (int i = 0; i < N_REQ; i++)
      for (int d = 0; d < DEPTH; d++)
        if (r_live[i][d]) pending = 1'b1;
  end

  assign in_ready   = w_ready;
  assign w_order    = r_out_valid && !f_match(r_out_ctx, w_hz_info);
  assign w_pa_rd    = r_out_pa;
  assign w_d_rd     = r_out_data;
  assign w_grant_id = r_out_gnt;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed cases plus random traffic against per-requester expected queues.
// Honours REG_WRITE_ARB_FIXED_PRIO_EN for the arbitration-order expectations.
module tb_reg_write_arbiter;
  localparam int N  = 2;
  localparam int D  = 2;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int CX = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic [N-1:0]      in_valid;
  logic [N*AW-1:0]   in_pa_rd;
  logic [N*DW-1:0]   in_data;
  logic [N*CX-1:0]   in_context;
  logic [N-1:0]      in_ready;
  logic              branch_hazard;
  logic [CX-1:0]     hazard_context_info;
  logic              w_order;
  logic [AW-1:0]     w_pa_rd;
  logic [DW-1:0]     w_d_rd;
  logic [0:0]        w_grant_id;
  logic              pending;

  always #5 clk = ~clk;

  reg_write_arbiter #(.N_REQ(N), .DEPTH(D), .LEN_PREG_ADDR(AW), .LEN_WORD(DW), .LEN_CONTEXT(CX)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_pa_rd(in_pa_rd), .in_data(in_data),
    .in_context(in_context), .in_ready(in_ready), .branch_hazard(branch_hazard),
    .hazard_context_info(hazard_context_info), .w_order(w_order), .w_pa_rd(w_pa_rd),
    .w_d_rd(w_d_rd), .w_grant_id(w_grant_id), .pending(pending)
  );

  typedef struct packed {
    logic [AW-1:0] pa;
    logic [DW-1:0] data;
    logic [CX-1:0] ctx;
  } ent_t;

  ent_t        sbq [N][$];
  ent_t        tmpq[$];
  ent_t        e;
  int          checks = 0;
  int          failures = 0;
  bit          chk_ready = 1'b0;
  int          acc_cnt [N];
  int          wr_cnt  [N];
  bit [63:0]   seen_pa = '0;
  bit          seen_dead = 1'b0;
  int          n_wr = 0;
  int          g;
  logic [CX-1:0] hz;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (pending && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, pending, 0);
    tick();
  endtask

  // Scoreboard: expected writes per requester, in acceptance order; flushes remove matching entries
  always @(negedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) sbq[i].delete();
    end else begin
      if (w_order) begin
        g = int'(w_grant_id);
        n_wr++;
        seen_pa[w_pa_rd] = 1'b1;
        if (w_d_rd == 32'hDEADBEEF) seen_dead = 1'b1;
        wr_cnt[g]++;
        if (sbq[g].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_write actual=pa %0d grant %0d required=no write", w_pa_rd, g);
        end else begin
          e = sbq[g].pop_front();
          chk("sb_pa", w_pa_rd, e.pa);
          chk("sb_data", w_d_rd, e.data);
        end
      end
      if (chk_ready)
        for (int i = 0; i < N; i++)
          chk("in_ready_vs_count", in_ready[i], ((acc_cnt[i] - wr_cnt[i]) < D));
      hz = branch_hazard ? hazard_context_info : '0;
      if (hz != '0) begin
        for (int i = 0; i < N; i++) begin
          tmpq = {};
          for (int k = 0; k < sbq[i].size(); k++)
            if ((sbq[i][k].ctx & hz) == '0) tmpq.push_back(sbq[i][k]);
          sbq[i] = tmpq;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          e.pa   = in_pa_rd[i*AW +: AW];
          e.data = in_data[i*DW +: DW];
          e.ctx  = in_context[i*CX +: CX];
          if (e.pa != '0 && (e.ctx & hz) == '0) begin
            sbq[i].push_back(e);
            acc_cnt[i]++;
          end
        end
      end
    end
  end

`ifdef REG_WRITE_ARB_FIXED_PRIO_EN
  int exp_pa [4] = '{5, 6, 7, 8};
  int exp_g  [4] = '{0, 0, 1, 1};
`else
  int exp_pa [4] = '{5, 7, 6, 8};
  int exp_g  [4] = '{0, 1, 0, 1};
`endif

  initial begin
    int i0, i1;
    bit a0, a1, saw_low0;
    int n0;
    for (int i = 0; i < N; i++) begin
      acc_cnt[i] = 0;
      wr_cnt[i]  = 0;
    end
    rstn = 1'b0;
    in_valid = '0; in_pa_rd = '0; in_data = '0; in_context = '0;
    branch_hazard = 1'b0; hazard_context_info = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_w_order", w_order, 0);
    chk("rst_in_ready", in_ready, 2'b11);
    chk("rst_pending", pending, 0);
    chk("rst_w_pa_rd", w_pa_rd, 0);
    chk("rst_w_d_rd", w_d_rd, 0);
    chk("rst_grant", w_grant_id, 0);
    tick();
    rstn = 1'b1;
    chk_ready = 1'b1;
    tick();

    // arbitration order
    in_valid = 2'b11;
    in_pa_rd = {6'd7, 6'd5};
    in_data  = {32'h0000_7007, 32'h0000_5005};
    tick();
    in_pa_rd = {6'd8, 6'd6};
    in_data  = {32'h0000_8008, 32'h0000_6006};
    @(negedge clk);
    chk("latency_not_before_2_edges", w_order, 0);
    tick();
    in_valid = 2'b00;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("arb_w_order", w_order, 1);
      chk("arb_pa", w_pa_rd, exp_pa[j]);
      chk("arb_grant", w_grant_id, exp_g[j]);
    end
    @(negedge clk);
    chk("arb_idle_after", w_order, 0);
    tick();

    // backpressure: requester 1 saturates while requester 0 pushes 4 values
    i0 = 0; i1 = 0; saw_low0 = 1'b0;
    for (int cyc = 0; cyc < 60 && i0 < 4; cyc++) begin
      in_valid = 2'b11;
      in_pa_rd = {6'(30 + (i1 % 20)), 6'(20 + i0)};
      in_data  = {32'(32'h1100 + i1), 32'(32'hA000 + i0)};
      @(negedge clk);
      a0 = in_ready[0];
      a1 = in_ready[1];
      if (!a0) saw_low0 = 1'b1;
      tick();
      if (a0) i0++;
      if (a1) i1++;
    end
    in_valid = 2'b00;
    chk("full_all_accepted", i0, 4);
    chk("full_backpressure_seen", saw_low0, 1);
    drain("full_drain_pending");

    // r0 write dropped
    n0 = n_wr;
    seen_dead = 1'b0;
    in_valid = 2'b01;
    in_pa_rd = '0;
    in_data  = {32'h0, 32'hDEADBEEF};
    @(negedge clk);
    chk("r0_ready_before", in_ready[0], 1);
    tick();
    in_valid = 2'b00;
    @(negedge clk);
    chk("r0_ready_after", in_ready[0], 1);
    chk("r0_pending", pending, 0);
    repeat (4) @(negedge clk);
    tick();
    chk("r0_no_write", n_wr - n0, 0);
    chk("r0_no_dead_data", seen_dead, 0);

    // flush of queued entries
    chk_ready = 1'b0;
    seen_pa = '0;
    in_valid   = 2'b11;
    in_pa_rd   = {6'd10, 6'd9};
    in_data    = {32'h0000_000A, 32'h0000_0009};
    in_context = {4'b0100, 4'b0010};
    tick();
    in_valid = 2'b00;
    branch_hazard = 1'b1;
    hazard_context_info = 4'b0010;
    tick();
    branch_hazard = 1'b0;
    drain("flush_pending");
    chk("flush_pa9_killed", seen_pa[9], 0);
    chk("flush_pa10_written", seen_pa[10], 1);

    // flush hitting the output register
    in_valid   = 2'b01;
    in_pa_rd   = {6'd0, 6'd12};
    in_data    = {32'h0, 32'h0000_000C};
    in_context = {4'b0000, 4'b0001};
    tick();
    in_valid = 2'b00;
    tick();
    branch_hazard = 1'b1;
    hazard_context_info = 4'b0001;
    @(negedge clk);
    chk("oflush_masked", w_order, 0);
    tick();
    branch_hazard = 1'b0;
    drain("oflush_pending");
    chk("oflush_not_retried", seen_pa[12], 0);

    // random traffic
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid   = 2'($urandom_range(0, 3));
      in_pa_rd   = {6'($urandom_range(0, 63)), 6'($urandom_range(0, 63))};
      in_data    = {$urandom, $urandom};
      in_context = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      branch_hazard = ($urandom_range(0, 9) == 0);
      hazard_context_info = 4'($urandom_range(1, 15));
      tick();
    end
    in_valid = 2'b00;
    branch_hazard = 1'b0;
    drain("rand_drain_pending");
    for (int i = 0; i < N; i++) chk("rand_leftover", sbq[i].size(), 0);

    // reset in the middle of traffic
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_valid   = 2'b11;
      in_pa_rd   = {6'($urandom_range(1, 63)), 6'($urandom_range(1, 63))};
      in_data    = {$urandom, $urandom};
      in_context = '0;
      tick();
    end
    in_valid = 2'b00;
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_w_order", w_order, 0);
    chk("midrst_pending", pending, 0);
    chk("midrst_in_ready", in_ready, 2'b11);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    seen_pa = '0;
    in_valid = 2'b10;
    in_pa_rd = {6'd33, 6'd0};
    in_data  = {32'h0000_3333, 32'h0};
    tick();
    in_valid = 2'b00;
    drain("post_rst_pending");
    chk("post_rst_written", seen_pa[33], 1);
    for (int i = 0; i < N; i++) chk("final_leftover", sbq[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
